hamming_serial_rx: RTL and testbench

Bit-serial receiver that sits directly upstream of the Hamming (7,4) decoder. It recovers framed 7-bit codewords from a strobed serial line and buffers them in a small first-word-fall-through FIFO. Codewords are presented to the decoder's 7-bit `code` input through a valid/ready handshake. Framing errors and FIFO overruns are flagged so link faults can be told apart from the single-bit errors the decoder corrects.

---
 rtl/hamming_serial_rx.sv | 95 +++++++++
 tb/tb_hamming_serial_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_serial_rx.sv
// hamming_serial_rx: recovers start/stop framed 7-bit codewords from a strobed serial line into a FWFT FIFO
module hamming_serial_rx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rx_bit_valid,
    input  logic                     i_rx_bit,
    output logic [6:0]               o_code_out,
    output logic                     o_code_valid,
    input  logic                     i_code_ready,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic                     o_overrun,
    output logic [7:0]               o_frame_err_cnt,
    input  logic                     i_clear_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
    state_t           r_state;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_shift;
    logic [6:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_overrun;
    logic [7:0]       r_err_cnt;
    logic             w_stop;
    logic             w_good;
    logic             w_bad;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    assign w_stop = i_rx_bit_valid && (r_state == STOP);
    assign w_good = w_stop && i_rx_bit;
    assign w_bad  = w_stop && !i_rx_bit;
    assign w_full = r_level == (AW+1)'(DEPTH);
    assign w_pop  = (r_level != '0) && i_code_ready;
    // a full FIFO still takes a frame when the head leaves in the same cycle
    assign w_push = w_good && (!w_full || w_pop);
    // frame receiver: only strobed cycles advance; a bad stop bit returns to IDLE without restarting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (i_rx_bit_valid) begin
            case (r_state)
                IDLE: begin
                    if (!i_rx_bit) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    r_shift[r_bit_cnt] <= i_rx_bit;
                    r_bit_cnt          <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd6) r_state <= STOP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // FIFO storage; contents need no reset because the output is gated by valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shift;
    end
    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    // sticky link-fault status; clearing wins over a same-cycle event
    always_ff @(posedge clk) begin
        if (rst || i_clear_err) begin
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_good && w_full && !w_pop) r_overrun <= 1'b1;
            if (w_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
    assign o_code_valid    = r_level != '0;
    assign o_code_out      = o_code_valid ? r_mem[r_rd_ptr] : '0;
    assign o_fifo_level    = r_level;
    assign o_overrun       = r_overrun;
    assign o_frame_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb_hamming_serial_rx: random and directed frames checked against a queue-based receiver model
module tb_hamming_serial_rx;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_rx_bit_valid = 1'b0;
    logic i_rx_bit = 1'b0;
    logic i_code_ready = 1'b0;
    logic i_clear_err = 1'b0;
    logic [6:0] o_code_out;
    logic o_code_valid;
    logic [$clog2(DEPTH):0] o_fifo_level;
    logic o_overrun;
    logic [7:0] o_frame_err_cnt;
    int checks = 0;
    int fails = 0;
    bit check_en = 0;
    hamming_serial_rx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_rx_bit_valid(i_rx_bit_valid), .i_rx_bit(i_rx_bit),
        .o_code_out(o_code_out), .o_code_valid(o_code_valid), .i_code_ready(i_code_ready),
        .o_fifo_level(o_fifo_level), .o_overrun(o_overrun), .o_frame_err_cnt(o_frame_err_cnt),
        .i_clear_err(i_clear_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", n, a, e, $time);
        end
    endtask
    // model: bits after a start bit are collected until eight are held; the eighth is the stop bit
    logic [6:0] q[$];
    bit bits[$];
    bit in_frame = 0;
    int m_err = 0;
    bit m_ovr = 0;
    bit m_good, m_bad, m_pop, m_full;
    logic [6:0] m_code;
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            bits.delete();
            in_frame = 0;
            m_err = 0;
            m_ovr = 0;
        end else begin
            m_good = 0;
            m_bad = 0;
            m_code = '0;
            if (i_rx_bit_valid) begin
                if (!in_frame) begin
                    if (!i_rx_bit) begin
                        in_frame = 1;
                        bits.delete();
                    end
                end else begin
                    bits.push_back(i_rx_bit);
                    if (bits.size() == 8) begin
                        in_frame = 0;
                        for (int k = 0; k < 7; k++) m_code[k] = bits[k];
                        m_good = bits[7];
                        m_bad = !bits[7];
                    end
                end
            end
            m_pop = q.size() != 0 && i_code_ready;
            m_full = q.size() == DEPTH;
            if (i_clear_err) begin
                m_err = 0;
                m_ovr = 0;
            end else begin
                if (m_bad && m_err < 255) m_err++;
                if (m_good && m_full && !m_pop) m_ovr = 1;
            end
            if (m_pop) void'(q.pop_front());
            if (m_good && (!m_full || m_pop)) q.push_back(m_code);
        end
    end
    always @(negedge clk) begin
        if (check_en) begin
            chk("code_valid", int'(o_code_valid), int'(q.size() != 0));
            chk("code_out", int'(o_code_out), q.size() != 0 ? int'(q[0]) : 0);
            chk("fifo_level", int'(o_fifo_level), q.size());
            chk("overrun", int'(o_overrun), int'(m_ovr));
            chk("frame_err_cnt", int'(o_frame_err_cnt), m_err);
        end
    end
    task automatic realign();
        @(posedge clk);
        #2;
    endtask
    task automatic drive(input bit v, input bit b);
        i_rx_bit_valid = v;
        i_rx_bit = b;
        realign();
    endtask
    task automatic idle(input int n);
        repeat (n) drive(0, 0);
    endtask
    task automatic send_frame(input logic [6:0] c, input bit stop, input int gap, input bit clr, input bit rdy_stop);
        logic prev;
        prev = i_code_ready;
        drive(1, 0);
        idle(gap);
        for (int i = 0; i < 7; i++) begin
            drive(1, c[i]);
            idle(gap);
        end
        i_code_ready = rdy_stop;
        i_clear_err = clr;
        drive(1, stop);
        i_rx_bit_valid = 0;
        i_clear_err = 0;
        i_code_ready = prev;
    endtask
    logic [6:0] codes [5];
    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_en = 1;
        @(negedge clk);
        chk("reset_valid", int'(o_code_valid), 0);
        chk("reset_code", int'(o_code_out), 0);
        chk("reset_level", int'(o_fifo_level), 0);
        rst = 0;
        realign();
        // single frame 0,1,0,1,1,0,1,0,1 -> code bits LSB first 1,0,1,1,0,1,0
        i_code_ready = 1;
        send_frame(7'b0101101, 1, 0, 0, 1);
        @(negedge clk);
        chk("first_code", int'(o_code_out), 7'h2D);
        chk("first_valid", int'(o_code_valid), 1);
        @(negedge clk);
        chk("first_valid_gone", int'(o_code_valid), 0);
        realign();
        // DEPTH+1 frames with no consumer
        i_code_ready = 0;
        for (int k = 0; k < 5; k++) begin
            codes[k] = 7'($urandom);
            send_frame(codes[k], 1, 0, 0, 0);
        end
        @(negedge clk);
        chk("ovr_level", int'(o_fifo_level), 4);
        chk("ovr_flag", int'(o_overrun), 1);
        chk("drain0", int'(o_code_out), int'(codes[0]));
        i_code_ready = 1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("drain", int'(o_code_out), int'(codes[k]));
        end
        @(negedge clk);
        chk("drain_empty", int'(o_code_valid), 0);
        realign();
        i_clear_err = 1;
        drive(0, 0);
        i_clear_err = 0;
        // bad stop bit, then a lone 1 strobe, then a good frame
        send_frame(7'($urandom), 0, 0, 0, 1);
        @(negedge clk);
        chk("ferr_one", int'(o_frame_err_cnt), 1);
        chk("ferr_no_push", int'(o_fifo_level), 0);
        realign();
        drive(1, 1);
        send_frame(7'h55, 1, 0, 0, 1);
        @(negedge clk);
        chk("after_ferr_code", int'(o_code_out), 7'h55);
        realign();
        // saturation and clearing
        repeat (300) send_frame(7'($urandom), 0, 0, 0, 1);
        @(negedge clk);
        chk("ferr_sat", int'(o_frame_err_cnt), 255);
        realign();
        i_clear_err = 1;
        drive(0, 0);
        i_clear_err = 0;
        @(negedge clk);
        chk("ferr_clear", int'(o_frame_err_cnt), 0);
        realign();
        send_frame(7'($urandom), 0, 0, 1, 1);
        @(negedge clk);
        chk("ferr_clear_same", int'(o_frame_err_cnt), 0);
        realign();
        // reset mid-frame with a full FIFO, strobes every third cycle
        i_code_ready = 0;
        repeat (4) send_frame(7'($urandom), 1, 0, 0, 0);
        drive(1, 0);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'($urandom));
            idle(2);
        end
        rst = 1;
        drive(0, 0);
        @(negedge clk);
        chk("rst_level", int'(o_fifo_level), 0);
        chk("rst_valid", int'(o_code_valid), 0);
        realign();
        rst = 0;
        i_code_ready = 1;
        send_frame(7'h3C, 1, 2, 0, 1);
        @(negedge clk);
        chk("post_rst_code", int'(o_code_out), 7'h3C);
        chk("post_rst_level", int'(o_fifo_level), 1);
        realign();
        idle(2);
        // full FIFO with a pop in the stop-bit cycle
        i_code_ready = 0;
        for (int k = 0; k < 5; k++) begin
            codes[k] = 7'($urandom);
            send_frame(codes[k], 1, 0, 0, k == 4);
        end
        @(negedge clk);
        chk("full_pop_level", int'(o_fifo_level), 4);
        chk("full_pop_ovr", int'(o_overrun), 0);
        chk("full_pop_head", int'(o_code_out), int'(codes[1]));
        realign();
        i_code_ready = 1;
        idle(6);
        // random traffic
        for (int f = 0; f < 60; f++) begin
            i_code_ready = 1'($urandom);
            send_frame(7'($urandom), ($urandom % 5) != 0, $urandom % 3, ($urandom % 10) == 0, 1'($urandom));
            idle($urandom % 3);
            if (($urandom % 4) == 0) drive(1, 1);
        end
        i_code_ready = 1;
        idle(8);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
